// File: rtl/systemizer_phase_ctrl_if.sv
// Handshake between the phase sequencer and the systemizer phase engine.
//   master : sequencer side, drives init/start/last-phase and receives done/fail
//   slave  : phase-engine side
// Signals:
//   ph_init_left / ph_init_right : one-cycle configuration pulses
//   ph_start / ph_start_block    : one-cycle launch pulse and the block it applies to
//   ph_last_phase                : high for the whole final phase
//   ph_done / ph_fail            : phase completion / failure from the engine
interface systemizer_phase_ctrl_if #(
  parameter int unsigned BW = 3
) ();

  logic          ph_init_left;
  logic          ph_init_right;
  logic          ph_start;
  logic [BW-1:0] ph_start_block;
  logic          ph_last_phase;
  logic          ph_done;
  logic          ph_fail;

  modport master (
    output ph_init_left,
    output ph_init_right,
    output ph_start,
    output ph_start_block,
    output ph_last_phase,
    input  ph_done,
    input  ph_fail
  );

  modport slave (
    input  ph_init_left,
    input  ph_init_right,
    input  ph_start,
    input  ph_start_block,
    input  ph_last_phase,
    output ph_done,
    output ph_fail
  );

endinterface

// File: rtl/systemizer_phase_ctrl.sv
// Sequencer for the single-pass systemizer phase datapath.
// A host start configures the phase engine with one init pulse (left or right),
// then launches one phase per column block from first_block up to the final
// block, waiting for ph_done between launches. ph_fail aborts the run. While a
// run is active the host matrix-memory strobes are gated off.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start, mode       : run request (IDLE only) and init side select (0 left, 1 right)
//   first_block       : first block index, sampled with start
//   busy, done, fail  : run status; done/fail are one-cycle pulses
//   phase_idx         : current block index (failing index kept after abort)
//   cycles            : saturating busy-cycle count of the last/current run
//   ph_if             : phase-engine handshake (master side)
//   host_rd_en/wr_en  : host memory strobes
//   ph_rd_en/wr_en    : gated strobes (combinational)
//   host_blocked      : registered flag, a host strobe was seen while busy
module systemizer_phase_ctrl #(
  parameter int unsigned N          = 4,
  parameter int unsigned L          = 8,
  parameter int unsigned K          = 16,
  parameter int unsigned NUM_PHASES = L / N,
  localparam int unsigned BW        = $clog2(K / N + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [BW-1:0]                  first_block,
  output logic                           busy,
  output logic                           done,
  output logic                           fail,
  output logic [BW-1:0]                  phase_idx,
  output logic [31:0]                    cycles,
  systemizer_phase_ctrl_if.master        ph_if,
  input  logic                           host_rd_en,
  input  logic                           host_wr_en,
  output logic                           ph_rd_en,
  output logic                           ph_wr_en,
  output logic                           host_blocked
);

  localparam logic [BW-1:0] NumPh   = BW'(NUM_PHASES);
  localparam logic [BW-1:0] LastIdx = BW'(NUM_PHASES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StLaunch,
    StWait,
    StGap,
    StFin,
    StAbort
  } state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [BW-1:0] phase_idx_q, phase_idx_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          init_left_q, init_left_d;
  logic          init_right_q, init_right_d;
  logic          ph_start_q, ph_start_d;
  logic [BW-1:0] start_block_q, start_block_d;
  logic          last_phase_q, last_phase_d;
  logic          host_blocked_q, host_blocked_d;

  // Every registered output is computed from the state being entered, so a
  // pulse belonging to a state is visible during the cycle that state is held.
  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    fail_d         = 1'b0;
    init_left_d    = 1'b0;
    init_right_d   = 1'b0;
    ph_start_d     = 1'b0;
    phase_idx_d    = phase_idx_q;
    start_block_d  = start_block_q;
    last_phase_d   = last_phase_q;
    cycles_d       = cycles_q;

    if (busy_q && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          cycles_d = '0;
          if (first_block >= NumPh) begin
            // Out-of-range first block: abort without touching the engine.
            state_d = StAbort;
            fail_d  = 1'b1;
          end else begin
            // mode/first_block are consumed here, so no separate latch is needed.
            state_d      = StInit;
            init_left_d  = ~mode;
            init_right_d = mode;
            phase_idx_d  = first_block;
          end
        end
      end

      StInit, StGap: begin
        state_d       = StLaunch;
        ph_start_d    = 1'b1;
        start_block_d = phase_idx_q;
        last_phase_d  = (phase_idx_q == LastIdx);
      end

      StLaunch: begin
        state_d = StWait;
      end

      StWait: begin
        if (ph_if.ph_fail) begin
          state_d      = StAbort;
          fail_d       = 1'b1;
          last_phase_d = 1'b0;
        end else if (ph_if.ph_done) begin
          last_phase_d = 1'b0;
          if (last_phase_q) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            state_d     = StGap;
            phase_idx_d = phase_idx_q + BW'(1);
          end
        end
      end

      StFin, StAbort: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d         = (state_d != StIdle);
    host_blocked_d = busy_q & (host_rd_en | host_wr_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fail_q         <= 1'b0;
      phase_idx_q    <= '0;
      cycles_q       <= '0;
      init_left_q    <= 1'b0;
      init_right_q   <= 1'b0;
      ph_start_q     <= 1'b0;
      start_block_q  <= '0;
      last_phase_q   <= 1'b0;
      host_blocked_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      fail_q         <= fail_d;
      phase_idx_q    <= phase_idx_d;
      cycles_q       <= cycles_d;
      init_left_q    <= init_left_d;
      init_right_q   <= init_right_d;
      ph_start_q     <= ph_start_d;
      start_block_q  <= start_block_d;
      last_phase_q   <= last_phase_d;
      host_blocked_q <= host_blocked_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign phase_idx    = phase_idx_q;
  assign cycles       = cycles_q;
  assign host_blocked = host_blocked_q;

  assign ph_if.ph_init_left   = init_left_q;
  assign ph_if.ph_init_right  = init_right_q;
  assign ph_if.ph_start       = ph_start_q;
  assign ph_if.ph_start_block = start_block_q;
  assign ph_if.ph_last_phase  = last_phase_q;

  // Host gating is combinational so a strobe is cut the same cycle busy rises.
  assign ph_rd_en = host_rd_en & ~busy_q;
  assign ph_wr_en = host_wr_en & ~busy_q;

endmodule

// File: tb/tb_systemizer_phase_ctrl.sv
// Self-checking bench for systemizer_phase_ctrl (N=4, L=8, K=16, NUM_PHASES=2).
// Expected per-cycle behaviour is derived from the run arithmetic: INIT takes
// one cycle, each phase takes (delay + 2) cycles, and the status pulse lands
// on the last busy cycle.
module tb_systemizer_phase_ctrl;

  localparam int NP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] first_block = '0;
  logic       busy, done, fail;
  logic [2:0] phase_idx;
  logic [31:0] cycles;
  logic       host_rd_en = 1'b0;
  logic       host_wr_en = 1'b0;
  logic       ph_rd_en, ph_wr_en, host_blocked;

  int n_checks = 0;
  int n_fail   = 0;

  systemizer_phase_ctrl_if #(.BW(3)) ph_if ();

  systemizer_phase_ctrl #(
    .N(4),
    .L(8),
    .K(16),
    .NUM_PHASES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .first_block (first_block),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .phase_idx   (phase_idx),
    .cycles      (cycles),
    .ph_if       (ph_if),
    .host_rd_en  (host_rd_en),
    .host_wr_en  (host_wr_en),
    .ph_rd_en    (ph_rd_en),
    .ph_wr_en    (ph_wr_en),
    .host_blocked(host_blocked)
  );

  always #5 clk = ~clk;

  initial begin
    ph_if.ph_done = 1'b0;
    ph_if.ph_fail = 1'b0;
  end

  // One run, entered and left at a negedge. Cycle 0 drives start; cycle k is
  // the k-th clock after it. fail_ph < 0 means no failure; otherwise the run's
  // fail_ph-th phase reports ph_fail together with ph_done.
  task automatic run_case(input string tag, input bit m, input logic [2:0] fb, input int dly,
                          input int fail_ph, input bit hw, input bit inject);
    bit   valid;
    int   nphase, exp_len, p, off;
    bit   exp_b, exp_st, exp_lp, exp_dn, exp_fl, exp_il, exp_ir, exp_hb, in_phase;
    bit   busy_prev, any_prev;
    logic [2:0] exp_blk;
    valid   = (int'(fb) < NP);
    nphase  = !valid ? 0 : (fail_ph < 0) ? (NP - int'(fb)) : (fail_ph + 1);
    exp_len = 1 + nphase * (dly + 2);

    start       = 1'b1;
    mode        = m;
    first_block = fb;
    host_wr_en  = hw;
    host_rd_en  = hw ? 1'($urandom_range(0, 1)) : 1'b0;
    busy_prev   = 1'b0;
    any_prev    = 1'b0;

    for (int k = 1; k <= exp_len + 1; k++) begin
      @(negedge clk);
      p        = (k >= 2) ? (k - 2) / (dly + 2) : 0;
      off      = (k >= 2) ? (k - 2) % (dly + 2) : 0;
      in_phase = valid && (k >= 2) && (p < nphase) && (off <= dly);
      exp_blk  = 3'(int'(fb) + p);
      exp_b    = (k <= exp_len);
      exp_il   = valid && (k == 1) && !m;
      exp_ir   = valid && (k == 1) && m;
      exp_st   = in_phase && (off == 0);
      exp_lp   = in_phase && (int'(exp_blk) == NP - 1);
      exp_dn   = valid && (fail_ph < 0) && (k == exp_len);
      exp_fl   = (!valid || fail_ph >= 0) && (k == exp_len);
      exp_hb   = busy_prev && any_prev;

      n_checks += 10;
      if (busy !== exp_b) begin
        n_fail++; $display("FAIL %s busy k=%0d got %b exp %b", tag, k, busy, exp_b);
      end
      if (done !== exp_dn) begin
        n_fail++; $display("FAIL %s done k=%0d got %b exp %b", tag, k, done, exp_dn);
      end
      if (fail !== exp_fl) begin
        n_fail++; $display("FAIL %s fail k=%0d got %b exp %b", tag, k, fail, exp_fl);
      end
      if (ph_if.ph_init_left !== exp_il) begin
        n_fail++;
        $display("FAIL %s init_left k=%0d got %b exp %b", tag, k, ph_if.ph_init_left, exp_il);
      end
      if (ph_if.ph_init_right !== exp_ir) begin
        n_fail++;
        $display("FAIL %s init_right k=%0d got %b exp %b", tag, k, ph_if.ph_init_right, exp_ir);
      end
      if (ph_if.ph_start !== exp_st) begin
        n_fail++; $display("FAIL %s ph_start k=%0d got %b exp %b", tag, k, ph_if.ph_start, exp_st);
      end
      if (ph_if.ph_last_phase !== exp_lp) begin
        n_fail++;
        $display("FAIL %s last_phase k=%0d got %b exp %b", tag, k, ph_if.ph_last_phase, exp_lp);
      end
      if (ph_wr_en !== (host_wr_en & ~exp_b)) begin
        n_fail++;
        $display("FAIL %s ph_wr_en k=%0d got %b exp %b", tag, k, ph_wr_en, host_wr_en & ~exp_b);
      end
      if (ph_rd_en !== (host_rd_en & ~exp_b)) begin
        n_fail++;
        $display("FAIL %s ph_rd_en k=%0d got %b exp %b", tag, k, ph_rd_en, host_rd_en & ~exp_b);
      end
      if (host_blocked !== exp_hb) begin
        n_fail++;
        $display("FAIL %s host_blocked k=%0d got %b exp %b", tag, k, host_blocked, exp_hb);
      end
      if (in_phase) begin
        n_checks++;
        if (ph_if.ph_start_block !== exp_blk) begin
          n_fail++;
          $display("FAIL %s start_block k=%0d got %0d exp %0d", tag, k, ph_if.ph_start_block,
                   exp_blk);
        end
      end

      if (k == exp_len + 1) begin
        n_checks++;
        if (cycles !== 32'(exp_len)) begin
          n_fail++; $display("FAIL %s cycles got %0d exp %0d", tag, cycles, exp_len);
        end
        if (valid) begin
          n_checks++;
          exp_blk = (fail_ph < 0) ? 3'(NP - 1) : 3'(int'(fb) + fail_ph);
          if (phase_idx !== exp_blk) begin
            n_fail++; $display("FAIL %s phase_idx got %0d exp %0d", tag, phase_idx, exp_blk);
          end
        end
      end

      // Drive inputs for cycle k.
      busy_prev = exp_b;
      any_prev  = host_wr_en | host_rd_en;
      start     = inject && (k == 3) && (exp_len >= 4);
      ph_if.ph_done = (in_phase && off == dly) || (inject && k == 1);
      ph_if.ph_fail = in_phase && (off == dly) && (p == fail_ph);
      if (k == exp_len + 1) begin
        host_wr_en = 1'b0;
        host_rd_en = 1'b0;
      end else if (hw) begin
        host_rd_en = 1'($urandom_range(0, 1));
      end
    end
    ph_if.ph_done = 1'b0;
    ph_if.ph_fail = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, fail, phase_idx, cycles, ph_if.ph_init_left, ph_if.ph_init_right,
         ph_if.ph_start, ph_if.ph_start_block, ph_if.ph_last_phase, ph_rd_en, ph_wr_en,
         host_blocked} !== '0) begin
      n_fail++; $display("FAIL reset_state busy=%b done=%b fail=%b idx=%0d cycles=%0d exp all 0",
                         busy, done, fail, phase_idx, cycles);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    run_case("full_run", 1'b0, 3'd0, 10, -1, 1'b0, 1'b0);
  endtask

  task automatic test_partial_run();
    run_case("partial_run", 1'b1, 3'd1, 10, -1, 1'b0, 1'b0);
  endtask

  task automatic test_fail();
    run_case("fail_with_done", 1'b0, 3'd0, 10, 0, 1'b0, 1'b0);
    run_case("fail_last", 1'b1, 3'd0, 4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_invalid();
    run_case("invalid_2", 1'b0, 3'd2, 5, -1, 1'b0, 1'b0);
    run_case("invalid_7", 1'b1, 3'd7, 5, -1, 1'b1, 1'b0);
  endtask

  task automatic test_gating();
    run_case("gating", 1'b0, 3'd0, 3, -1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; mode = 1'b0; first_block = 3'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, fail, phase_idx, cycles, ph_if.ph_init_left, ph_if.ph_init_right,
         ph_if.ph_start, ph_if.ph_start_block, ph_if.ph_last_phase, ph_rd_en, ph_wr_en,
         host_blocked} !== '0) begin
      n_fail++; $display("FAIL reset_mid_run busy=%b idx=%0d cycles=%0d start=%b lp=%b exp all 0",
                         busy, phase_idx, cycles, ph_if.ph_start, ph_if.ph_last_phase);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_case("after_reset", 1'b1, 3'd0, 6, -1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_case("b2b_a", 1'b0, 3'd1, 2, -1, 1'b0, 1'b0);
    run_case("b2b_b", 1'b1, 3'd0, 1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int   nph, r, fph, dly;
    logic [2:0] fb;
    for (int i = 0; i < 10; i++) begin
      fb  = 3'($urandom_range(0, 2));
      dly = int'($urandom_range(1, 12));
      nph = NP - int'(fb);
      fph = -1;
      if (nph > 0) begin
        r   = int'($urandom_range(0, nph));
        fph = (r == nph) ? -1 : r;
      end
      run_case("random", 1'($urandom_range(0, 1)), fb, dly, fph, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_partial_run();
    test_fail();
    test_invalid();
    test_gating();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
